// File: rtl/reg_file_hs.sv
// Multi-port register file with four-phase req/ack handshakes per port, a PC alias
// on register DEPTH-1 and a separate CPSR. Define REG_FILE_HS_BYPASS_EN for write-to-read bypass.
module reg_file_hs #(
  parameter int N     = 32,
  parameter int DEPTH = 16,
  parameter int NR    = 4,
  parameter int NW    = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR-1:0]    rd_req,
  input  logic [NR*AW-1:0] rd_addr,
  output logic [NR-1:0]    rd_ack,
  output logic [NR*N-1:0]  rd_data,
  input  logic [NW-1:0]    wr_req,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic [NW*N-1:0]  wr_data,
  output logic [NW-1:0]    wr_ack,
  input  logic             pc_write,
  input  logic [N-1:0]     pc_update,
  output logic [N-1:0]     pc,
  input  logic             cpsr_write,
  input  logic [N-1:0]     cpsr_update,
  output logic [N-1:0]     cpsr
);

  localparam logic [AW:0]   DEPTH_W = DEPTH[AW:0];
  localparam logic [AW-1:0] PC_ADDR = AW'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t        rd_state [NR];
  state_t        wr_state [NW];
  logic [N-1:0]  regs     [DEPTH];
  logic [AW-1:0] ra       [NR];
  logic [N-1:0]  rd_val   [NR];
  logic [N-1:0]  rd_q     [NR];
  logic [AW-1:0] wa       [NW];
  logic [N-1:0]  wd       [NW];
  logic [NW-1:0] wr_go;
  logic [NW-1:0] wr_gnt;
  logic [N-1:0]  cpsr_q;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  for (genvar i = 0; i < NR; i++) begin : g_rd
    assign ra[i]               = rd_addr[i*AW +: AW];
    assign rd_ack[i]           = (rd_state[i] == ACK);
    assign rd_data[i*N +: N]   = rd_q[i];
  end

  for (genvar w = 0; w < NW; w++) begin : g_wr
    assign wa[w]     = wr_addr[w*AW +: AW];
    assign wd[w]     = wr_data[w*N +: N];
    assign wr_go[w]  = (wr_state[w] == IDLE) && wr_req[w];
    assign wr_ack[w] = (wr_state[w] == ACK);
  end

  assign pc   = regs[DEPTH-1];
  assign cpsr = cpsr_q;

  // Lowest contending port wins an address; pc_write pre-empts any port aimed at the PC.
  always_comb begin
    wr_gnt = '0;
    for (int w = 0; w < NW; w++) begin
      wr_gnt[w] = wr_go[w] && !(pc_write && wa[w] == PC_ADDR);
      for (int j = 0; j < w; j++)
        if (wr_go[j] && wa[j] == wa[w]) wr_gnt[w] = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      rd_val[i] = '0;
      if (in_range(ra[i])) begin
        rd_val[i] = regs[ra[i]];
`ifdef REG_FILE_HS_BYPASS_EN
        for (int w = 0; w < NW; w++)
          if (wr_gnt[w] && wa[w] == ra[i]) rd_val[i] = wd[w];
        if (pc_write && ra[i] == PC_ADDR) rd_val[i] = pc_update;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the register array is architecturally visible after reset, so it is cleared here
      // rather than left uninitialised like a RAM macro.
      for (int d = 0; d < DEPTH; d++) regs[d] <= '0;
      for (int i = 0; i < NR; i++) begin
        rd_state[i] <= IDLE;
        rd_q[i]     <= '0;
      end
      for (int w = 0; w < NW; w++) wr_state[w] <= IDLE;
      cpsr_q <= '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (rd_state[i] == IDLE) begin
          if (rd_req[i]) begin
            rd_q[i]     <= rd_val[i];
            rd_state[i] <= ACK;
          end
        end else if (!rd_req[i]) begin
          rd_state[i] <= IDLE;
        end
      end
      for (int w = 0; w < NW; w++) begin
        if (wr_state[w] == IDLE) begin
          if (wr_gnt[w]) begin
            if (in_range(wa[w])) regs[wa[w]] <= wd[w];
            wr_state[w] <= ACK;
          end
        end else if (!wr_req[w]) begin
          wr_state[w] <= IDLE;
        end
      end
      if (pc_write)   regs[DEPTH-1] <= pc_update;
      if (cpsr_write) cpsr_q        <= cpsr_update;
    end
  end

endmodule

// File: tb/tb_reg_file_hs.sv
// Directed self-checking bench for reg_file_hs (default parameters); expectations
// follow REG_FILE_HS_BYPASS_EN when the bench is compiled with it.
module tb_reg_file_hs;

  localparam int N = 32, DEPTH = 16, NR = 4, NW = 2, AW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    rd_req;
  logic [NR*AW-1:0] rd_addr;
  logic [NR-1:0]    rd_ack;
  logic [NR*N-1:0]  rd_data;
  logic [NW-1:0]    wr_req;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*N-1:0]  wr_data;
  logic [NW-1:0]    wr_ack;
  logic             pc_write;
  logic [N-1:0]     pc_update;
  logic [N-1:0]     pc;
  logic             cpsr_write;
  logic [N-1:0]     cpsr_update;
  logic [N-1:0]     cpsr;

  int n_checks = 0;
  int n_pass   = 0;

  reg_file_hs #(.N(N), .DEPTH(DEPTH), .NR(NR), .NW(NW)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .pc_write(pc_write), .pc_update(pc_update), .pc(pc),
    .cpsr_write(cpsr_write), .cpsr_update(cpsr_update), .cpsr(cpsr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] rdp(input int i);
    return rd_data[i*N +: N];
  endfunction

  task automatic set_rd(input int i, input logic req, input logic [AW-1:0] a);
    rd_req[i]            = req;
    rd_addr[i*AW +: AW]  = a;
  endtask

  task automatic set_wr(input int w, input logic req, input logic [AW-1:0] a, input logic [N-1:0] d);
    wr_req[w]            = req;
    wr_addr[w*AW +: AW]  = a;
    wr_data[w*N +: N]    = d;
  endtask

  logic [N-1:0] exp_byp;

  initial begin
    rst = 1'b1; rd_req = '0; rd_addr = '0; wr_req = '0; wr_addr = '0; wr_data = '0;
    pc_write = 1'b0; pc_update = '0; cpsr_write = 1'b0; cpsr_update = '0;
    tick(); tick();
    check("reset_rd_ack", N'(rd_ack), '0);
    check("reset_wr_ack", N'(wr_ack), '0);
    check("reset_pc", pc, '0);
    check("reset_cpsr", cpsr, '0);
    rst = 1'b0;
    tick();

    // Read of a reset register: one-edge latency, zero data.
    set_rd(0, 1'b1, 4'd3);
    tick();
    check("rd0_ack", N'(rd_ack[0]), 1);
    check("rd0_data", rdp(0), 32'h0);
    set_rd(0, 1'b0, 4'd3);
    tick();
    check("rd0_ack_drop", N'(rd_ack[0]), 0);

    // Write then read back on another port; data held while req stays high.
    set_wr(0, 1'b1, 4'd5, 32'hDEAD_BEEF);
    tick();
    check("wr0_ack", N'(wr_ack[0]), 1);
    wr_req[0] = 1'b0;
    tick();
    check("wr0_ack_drop", N'(wr_ack[0]), 0);
    set_rd(2, 1'b1, 4'd5);
    tick();
    check("rd2_ack", N'(rd_ack[2]), 1);
    check("rd2_data", rdp(2), 32'hDEAD_BEEF);
    set_rd(2, 1'b1, 4'd3);
    tick();
    check("rd2_hold", rdp(2), 32'hDEAD_BEEF);
    set_rd(2, 1'b0, 4'd3);
    tick();

    // Same-address collision: port 0 first, port 1 one edge later.
    set_wr(0, 1'b1, 4'd7, 32'h11);
    set_wr(1, 1'b1, 4'd7, 32'h22);
    tick();
    check("coll_edge1", N'(wr_ack), 32'h1);
    tick();
    check("coll_edge2", N'(wr_ack), 32'h3);
    wr_req = '0;
    tick();
    check("coll_release", N'(wr_ack), 32'h0);
    set_rd(1, 1'b1, 4'd7);
    tick();
    check("coll_r7", rdp(1), 32'h22);
    set_rd(1, 1'b0, 4'd7);
    tick();

    // pc_write pre-empts a port writing the PC register.
    set_wr(1, 1'b1, 4'd15, 32'h100);
    pc_write = 1'b1; pc_update = 32'h200;
    tick();
    check("pc_first", pc, 32'h200);
    check("pc_stall_ack", N'(wr_ack[1]), 0);
    pc_write = 1'b0;
    tick();
    check("pc_second", pc, 32'h100);
    check("pc_port_ack", N'(wr_ack[1]), 1);
    wr_req[1] = 1'b0;
    tick();

    // CPSR load only when cpsr_write is high.
    cpsr_write = 1'b1; cpsr_update = 32'hA5A5_0F0F;
    tick();
    check("cpsr_load", cpsr, 32'hA5A5_0F0F);
    cpsr_write = 1'b0; cpsr_update = 32'h1234_5678;
    tick();
    check("cpsr_hold", cpsr, 32'hA5A5_0F0F);

    // Same-cycle read and write of R4.
`ifdef REG_FILE_HS_BYPASS_EN
    exp_byp = 32'h55;
`else
    exp_byp = 32'h0;
`endif
    set_rd(3, 1'b1, 4'd4);
    set_wr(0, 1'b1, 4'd4, 32'h55);
    tick();
    check("rw_same_cycle", rdp(3), exp_byp);
    rd_req = '0; wr_req = '0;
    tick();
    set_rd(3, 1'b1, 4'd4);
    tick();
    check("rw_after", rdp(3), 32'h55);
    rd_req = '0;
    tick();

    // Asynchronous reset during an active read and write.
    set_rd(1, 1'b1, 4'd7);
    set_wr(0, 1'b1, 4'd9, 32'h77);
    tick();
    check("pre_rst_rd_ack", N'(rd_ack[1]), 1);
    check("pre_rst_wr_ack", N'(wr_ack[0]), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_rd_ack", N'(rd_ack), 0);
    check("rst_wr_ack", N'(wr_ack), 0);
    check("rst_rd_data1", rdp(1), 0);
    check("rst_pc", pc, 0);
    check("rst_cpsr", cpsr, 0);
    rd_req = '0; wr_req = '0;
    tick();
    rst = 1'b0;
    tick();
    set_rd(0, 1'b1, 4'd7);
    set_rd(1, 1'b1, 4'd9);
    set_rd(2, 1'b1, 4'd5);
    tick();
    check("post_rst_ack", N'(rd_ack[2:0]), 32'h7);
    check("post_rst_r7", rdp(0), 0);
    check("post_rst_r9", rdp(1), 0);
    check("post_rst_r5", rdp(2), 0);
    rd_req = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_hs.md
REG_FILE_HS -- requirements
Module: reg_file_hs

Interface
REQ-001 Parameter N, default 32, register data width in bits.
REQ-002 Parameter DEPTH, default 16, number of general registers; AW = clog2(DEPTH); register DEPTH-1 is the PC.
REQ-003 Parameter NR, default 4, number of read ports.
REQ-004 Parameter NW, default 2, number of write ports.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 rd_req  in  NR  per-port read request, four-phase.
REQ-008 rd_addr  in  NR*AW  read addresses, port i at bits [i*AW +: AW].
REQ-009 rd_ack  out  NR  per-port read acknowledge.
REQ-010 rd_data  out  NR*N  read data, port i at bits [i*N +: N].
REQ-011 wr_req  in  NW  per-port write request, four-phase.
REQ-012 wr_addr  in  NW*AW  write addresses.
REQ-013 wr_data  in  NW*N  write data.
REQ-014 wr_ack  out  NW  per-port write acknowledge.
REQ-015 pc_write  in  1  load PC this cycle; pc_update  in  N  new PC value.
REQ-016 pc  out  N  always equals register DEPTH-1.
REQ-017 cpsr_write  in  1  load CPSR this cycle; cpsr_update  in  N  new CPSR; cpsr  out  N  registered CPSR.

Function
REQ-018 Each port has an independent FSM with states IDLE and ACK.
REQ-019 IDLE, req=1 at edge, access granted -> access performed at that edge, ack=1 from that edge (one-cycle latency), state ACK.
REQ-020 ACK, req=1 -> hold ack=1 and rd_data stable; req=0 -> ack=0 at that edge, state IDLE.
REQ-021 A new request is only sampled in IDLE, so at least one cycle with ack=0 separates transactions.
REQ-022 Reads are always granted; read of address >= DEPTH returns 0.
REQ-023 Writes to distinct addresses in the same cycle all complete that edge.
REQ-024 Same-address write collision: lowest-index port is granted; others stay IDLE with ack=0 and retry next edge.
REQ-025 pc_write has priority over any write port targeting DEPTH-1; that port is stalled one cycle, then granted (overwriting pc).
REQ-026 Write to address >= DEPTH: no register changes, ack still given.
REQ-027 cpsr_write loads cpsr at the edge; no handshake.
REQ-028 Read and granted write to same address in the same cycle: returned data per Configuration.
REQ-029 Requests withdrawn (req=0) while IDLE are ignored; no state change.

Reset
REQ-030 rst=1 immediately forces all registers, pc, cpsr, rd_data to 0, all acks to 0, all FSMs to IDLE, independent of clk.
REQ-031 Reset mid-transaction aborts it; in-flight write is not performed unless its edge preceded rst assertion.
REQ-032 After rst deasserts, first edge with req=1 is serviced normally.

Configuration
REQ-033 Macro REG_FILE_HS_BYPASS_EN defined: same-cycle read of an address being written returns the new write data (winning write, or pc_update for DEPTH-1).
REQ-034 Macro undefined: same-cycle read returns the pre-write register value; new value visible to reads starting the following edge.

Verification
REQ-035 Reset, then read port 0 addr 3 -> rd_ack[0]=1 one edge after rd_req, rd_data port 0 = 0x00000000.
REQ-036 Write port 0 addr 5 data 0xDEADBEEF, release, read port 2 addr 5 -> 0xDEADBEEF; wr_ack low one edge after wr_req falls.
REQ-037 Write ports 0 and 1 both addr 7 (0x11, 0x22) same edge -> wr_ack[0] first edge, wr_ack[1] next edge, final R7=0x22.
REQ-038 Write port 1 addr 15 data 0x100 with pc_write=1 pc_update=0x200 same edge -> pc=0x200 then 0x100 one edge later.
REQ-039 Read addr 4 same edge as write 0x55 to addr 4 (R4 was 0) -> rd_data=0x55 with BYPASS_EN, 0x0 without.
REQ-040 Assert rst while rd_ack[1]=1 and write in progress -> all acks 0 and all registers 0 immediately, no clk edge needed.
